status_packet_tx: RTL and testbench
===================================

// Module: status_packet_tx
// PURPOSE
//  Status packet source (leaf) for the 8-bit status router tree. Snapshots a
//  payload vector and sends it upstream as one packet over db/rq/start.
//  Packet: {ADDR byte, NUM_PAYLOAD payload bytes LSB first, {mode,seq} byte}.
//  Sends on software command, on payload change, or continuously.
// PARAMETERS
//  NUM_PAYLOAD  4     payload bytes per packet, 1..14; packet = NUM_PAYLOAD+2 bytes
//  ADDR         8'h00 first byte of every packet (status slot address)
// PORTS
//  rst        in   1   reset, asynchronous, active-high
//  clk        in   1   clock
//  cmd_we     in   1   write mode/sequence register
//  cmd_data   in   8   [7:6] mode, [5:0] sequence number
//  payload    in   8*NUM_PAYLOAD  live status bits, byte 0 = [7:0]
//  db_out     out  8   packet byte toward router
//  rq_out     out  1   request / packet-continues flag
//  start_in   in   1   router accepts first byte (combinational from rq_out)
//  busy       out  1   packet pending or in flight
// BEHAVIOUR
//  Reset (async): state IDLE, rq_out=0, db_out=0, busy=0, mode=0, seq=0,
//   last_sent=0, pending=0.
//  Protocol: rq_out high with byte0 on db_out until start_in=1 (byte0 taken
//   that cycle); then exactly one byte taken per cycle, no backpressure;
//   rq_out stays 1 for all bytes except the last, last byte has rq_out=0.
//  Modes: 0 off; 1 single (send one packet, mode->0 at snapshot);
//   2 on-change (send when payload != last_sent); 3 always (resend forever).
//  cmd_we: mode,seq <= cmd_data next edge; mode 1..3 sets pending.
//   In-flight packet never altered; mode 0 clears pending but not a packet
//   already in REQ/SEND.
//  FSM:
//   IDLE: db_out=0, rq_out=0. If pending, or mode==2 && payload!=last_sent,
//    or mode==3: snapshot payload into shift reg, last_sent<=payload,
//    tail<={mode,seq}, clear pending, mode 1->0; go REQ.
//   REQ: rq_out=1, db_out=ADDR; wait any number of cycles; start_in=1 ->
//    SEND with idx=1.
//   SEND: db_out=byte[idx] (payload bytes idx 1..NUM_PAYLOAD, tail at
//    idx=NUM_PAYLOAD+1); rq_out=(idx!=NUM_PAYLOAD+1); idx++ each cycle;
//    at last byte: seq<=seq+1 (mod 64), go IDLE.
//  Latency: pending at IDLE -> rq_out=1 next cycle. Packet occupies
//   NUM_PAYLOAD+2 cycles from start_in. Min gap between packets: 1 IDLE
//   cycle after last byte (rq_out low 2 cycles).
//  start_in ignored outside REQ (no effect, no error).
//  cmd_we in same cycle as seq increment: cmd_data wins.
//  cmd_we mode 1 during REQ/SEND: pending held, packet sent after current.
//  Payload changes during REQ/SEND do not affect in-flight bytes; mode 2
//   re-evaluates against last_sent on return to IDLE.
//  busy = pending | (state!=IDLE).
//  Mid-packet reset: rq_out drops immediately; router tree shares rst.
// TESTING
//  NUM_PAYLOAD=4, ADDR=8'h5A; cmd 8'h45 (mode1 seq5), payload 32'h44332211,
//   start_in 3 cycles after rq -> bytes 5A,11,22,33,44,45; rq 1 through 44,
//   0 on 45; mode reads 0, seq 6, no second packet.
//  Mode 2 (cmd 8'h80), payload stable 20 cycles -> one packet only; change
//   payload byte1 -> exactly one more packet, tail 8'h81.
//  Mode 3, start_in whenever rq -> back-to-back packets, 1 idle cycle
//   between, seq tail 3F then 00 (wrap).
//  cmd_we 8'h40 during SEND and in last-byte cycle -> current packet intact,
//   next packet tail 8'h40 (cmd beats increment), seq then 01.
//  rst asserted in SEND idx=2 -> rq_out=0, db_out=0 same cycle; after
//   release no packet until new cmd_we.
//  start_in pulsed while IDLE -> no output activity.

Source files
------------

// File: rtl/status_packet_tx.sv
// rtl/status_packet_tx.sv - status packet source leaf for the 8-bit status router tree
module status_packet_tx #(
  parameter int         NUM_PAYLOAD = 4,
  parameter logic [7:0] ADDR        = 8'h00
) (
  input  logic                     rst,
  input  logic                     clk,
  input  logic                     cmd_we,
  input  logic [7:0]               cmd_data,
  input  logic [8*NUM_PAYLOAD-1:0] payload,
  output logic [7:0]               db_out,
  output logic                     rq_out,
  input  logic                     start_in,
  output logic                     busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] SEND = 2'd2;

  localparam logic [3:0] LAST_IDX = 4'(NUM_PAYLOAD + 1);

  logic [1:0]               state;
  logic [1:0]               mode;
  logic [5:0]               seq;
  logic                     pending;
  logic [8*NUM_PAYLOAD-1:0] last_sent;
  logic [8*NUM_PAYLOAD-1:0] snap;
  logic [7:0]               tail;
  logic [3:0]               idx;
  logic                     trigger;

  assign trigger = pending || (mode == 2'd2 && payload != last_sent) || (mode == 2'd3);
  assign busy    = pending || (state != IDLE);

  // Outputs decode straight from state so an async reset drops rq_out at once.
  always_comb begin
    db_out = 8'h00;
    rq_out = 1'b0;
    case (state)
      REQ: begin
        db_out = ADDR;
        rq_out = 1'b1;
      end
      SEND: begin
        db_out = (idx == LAST_IDX) ? tail : snap[7:0];
        rq_out = (idx != LAST_IDX);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mode      <= 2'd0;
      seq       <= 6'd0;
      pending   <= 1'b0;
      last_sent <= '0;
      snap      <= '0;
      tail      <= 8'h00;
      idx       <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            snap      <= payload;
            last_sent <= payload;
            tail      <= {mode, seq};
            pending   <= 1'b0;
            if (mode == 2'd1) mode <= 2'd0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (start_in) begin
            idx   <= 4'd1;
            state <= SEND;
          end
        end
        SEND: begin
          // Payload bytes leave LSB first out of the low byte of the snapshot.
          snap <= snap >> 8;
          idx  <= idx + 4'd1;
          if (idx == LAST_IDX) begin
            seq   <= seq + 6'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Placed last so a software write overrides snapshot and sequence updates.
      if (cmd_we) begin
        mode    <= cmd_data[7:6];
        seq     <= cmd_data[5:0];
        pending <= (cmd_data[7:6] != 2'd0);
      end
    end
  end

endmodule

// File: tb/tb_status_packet_tx.sv
// tb/tb_status_packet_tx.sv - randomized self-checking bench for status_packet_tx
module tb_status_packet_tx;

  localparam int         N    = 4;
  localparam logic [7:0] ADDR = 8'h5A;

  logic           rst;
  logic           clk;
  logic           cmd_we;
  logic [7:0]     cmd_data;
  logic [8*N-1:0] payload;
  logic [7:0]     db_out;
  logic           rq_out;
  logic           start_in;
  logic           busy;

  int errors = 0;
  int checks = 0;

  logic [5:0]  m_seq;
  logic [31:0] m_last;
  logic [31:0] cur_pl;

  status_packet_tx #(.NUM_PAYLOAD(N), .ADDR(ADDR)) dut (
    .rst(rst), .clk(clk), .cmd_we(cmd_we), .cmd_data(cmd_data), .payload(payload),
    .db_out(db_out), .rq_out(rq_out), .start_in(start_in), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] v);
    cmd_we   = 1'b1;
    cmd_data = v;
    step();
    cmd_we   = 1'b0;
  endtask

  task automatic wait_rq(output int waited);
    waited = -1;
    for (int i = 0; i < 40; i++) begin
      if (rq_out) begin
        waited = i;
        break;
      end
      step();
    end
  endtask

  task automatic quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (rq_out || db_out != 8'h00 || busy) seen = 1'b1;
      step();
    end
    check(tag, {31'd0, seen}, 32'd0);
  endtask

  // Expected packet = {ADDR, payload bytes LSB first, tail}; optional cmd writes on byte slots.
  task automatic expect_packet(input string tag, input logic [31:0] pl, input logic [7:0] tl,
                               input int dly, input int cmd_from, input int cmd_to,
                               input logic [7:0] cmd_v);
    int         w;
    logic [7:0] exp_b;
    logic       exp_rq;
    wait_rq(w);
    check({tag, " rq seen"}, {31'd0, (w >= 0)}, 32'd1);
    if (w < 0) return;
    for (int d = 0; d < dly; d++) begin
      check({tag, " hold"}, {23'd0, rq_out, db_out}, {23'd0, 1'b1, ADDR});
      step();
    end
    for (int k = 0; k <= N + 1; k++) begin
      exp_b  = (k == 0) ? ADDR : (k == N + 1) ? tl : pl[8*(k-1) +: 8];
      exp_rq = (k != N + 1);
      cmd_we   = (k >= cmd_from && k <= cmd_to);
      cmd_data = cmd_v;
      start_in = (k == 0);
      check($sformatf("%s b%0d", tag, k), {24'd0, db_out}, {24'd0, exp_b});
      check($sformatf("%s rq%0d", tag, k), {31'd0, rq_out}, {31'd0, exp_rq});
      step();
    end
    cmd_we   = 1'b0;
    start_in = 1'b0;
  endtask

  initial begin
    int         w;
    int         op;
    logic       go;
    logic [5:0] s;

    rst = 1'b1; cmd_we = 1'b0; cmd_data = 8'h00; payload = '0; start_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset rq", {31'd0, rq_out}, 32'd0);
    check("reset db", {24'd0, db_out}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    step();
    check("post reset rq", {31'd0, rq_out}, 32'd0);

    // single-shot mode
    cur_pl = 32'h44332211; payload = cur_pl;
    send_cmd(8'h45);
    check("t1 busy pending", {31'd0, busy}, 32'd1);
    wait_rq(w);
    check("t1 latency", w, 32'd1);
    expect_packet("t1", cur_pl, 8'h45, 3, -1, -1, 8'h00);
    check("t1 mode", {30'd0, dut.mode}, 32'd0);
    check("t1 seq", {26'd0, dut.seq}, 32'd6);
    quiet("t1 no second", 20);
    m_last = cur_pl;

    // on-change mode
    send_cmd(8'h80);
    expect_packet("t2a", cur_pl, 8'h80, 1, -1, -1, 8'h00);
    quiet("t2 stable", 20);
    cur_pl = 32'h4433AA11; payload = cur_pl;
    expect_packet("t2b", cur_pl, 8'h81, 0, -1, -1, 8'h00);
    quiet("t2 after change", 10);
    m_last = cur_pl;
    m_seq  = 6'd2;

    // randomized on-change traffic
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 2);
      go = 1'b0;
      if (op == 2) begin
        s = 6'($urandom_range(0, 63));
        send_cmd({2'b10, s});
        m_seq = s;
        go = 1'b1;
      end else if (op == 0) begin
        cur_pl = $urandom;
        if ($urandom_range(0, 3) == 0) cur_pl = m_last;
        payload = cur_pl;
        go = (cur_pl != m_last);
      end
      if (go) begin
        expect_packet($sformatf("rand%0d", it), cur_pl, {2'b10, m_seq},
                      $urandom_range(0, 4), -1, -1, 8'h00);
        m_last = cur_pl;
        m_seq  = m_seq + 6'd1;
      end else begin
        quiet($sformatf("rand%0d idle", it), 6);
      end
    end

    // continuous mode with sequence wrap, stopped mid-packet
    send_cmd(8'hFF);
    expect_packet("t5a", cur_pl, 8'hFF, 0, -1, -1, 8'h00);
    check("t5 gap", {31'd0, rq_out}, 32'd0);
    step();
    check("t5 next req", {31'd0, rq_out}, 32'd1);
    expect_packet("t5b", cur_pl, 8'hC0, 0, 2, 2, 8'h00);
    quiet("t5 stopped", 15);
    check("t5 seq", {26'd0, dut.seq}, 32'd1);

    // software write during SEND and in the last-byte cycle
    send_cmd(8'h85);
    expect_packet("t6a", cur_pl, 8'h85, 2, 2, N + 1, 8'h40);
    expect_packet("t6b", cur_pl, 8'h40, 1, -1, -1, 8'h00);
    check("t6 seq", {26'd0, dut.seq}, 32'd1);
    check("t6 mode", {30'd0, dut.mode}, 32'd0);
    quiet("t6 done", 10);

    start_in = 1'b1;
    quiet("t7 start idle", 10);
    start_in = 1'b0;

    // reset in the middle of a packet
    send_cmd(8'h41);
    wait_rq(w);
    check("t8 rq seen", {31'd0, (w >= 0)}, 32'd1);
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    step();
    check("t8 byte2", {24'd0, db_out}, {24'd0, cur_pl[15:8]});
    rst = 1'b1;
    #1;
    check("t8 rq drop", {31'd0, rq_out}, 32'd0);
    check("t8 db drop", {24'd0, db_out}, 32'd0);
    check("t8 busy drop", {31'd0, busy}, 32'd0);
    step();
    step();
    rst = 1'b0;
    quiet("t8 after reset", 20);
    check("t8 seq", {26'd0, dut.seq}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
